// File: rtl/serial_disp_sched_if.sv
// Requester-side bus of the display scheduler: frame requests, data and acks.
interface serial_disp_sched_if #(
  parameter int unsigned SEG_BITS = 64,
  parameter int unsigned LED_BITS = 16
);
  logic                seg_req;
  logic [SEG_BITS-1:0] seg_data;
  logic                seg_ack;
  logic                led_req;
  logic [LED_BITS-1:0] led_data;
  logic                led_ack;
  logic                busy;

  modport master (output seg_req, seg_data, led_req, led_data,
                  input  seg_ack, led_ack, busy);
  modport slave  (input  seg_req, seg_data, led_req, led_data,
                  output seg_ack, led_ack, busy);
endinterface

// File: rtl/serial_disp_sched.sv
// Round-robin scheduler sharing one serial shift engine between the seven-segment
// and LED chains. Optional auto-refresh of shadowed frames: SERIAL_DISP_AUTO_REFRESH_EN.
module serial_disp_sched #(
  parameter int unsigned SEG_BITS = 64,
  parameter int unsigned LED_BITS = 16,
  parameter int unsigned CLK_DIV  = 4
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
  , parameter int unsigned REFRESH_CYCLES = 1000000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  serial_disp_sched_if.slave  bus_if,
  output logic                seg_clk_o,
  output logic                seg_pen_o,
  output logic                seg_do_o,
  output logic                led_clk_o,
  output logic                led_pen_o,
  output logic                led_do_o
);

  localparam int unsigned BIT_W   = $clog2(SEG_BITS);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned LED_PAD = SEG_BITS - LED_BITS;
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
  localparam int unsigned REF_W   = $clog2(REFRESH_CYCLES + 1);
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  localparam logic CH_SEG = 1'b0;
  localparam logic CH_LED = 1'b1;

  logic [1:0]          state_q, state_d;
  logic                chan_q, chan_d;
  logic                last_q, last_d;
  logic [SEG_BITS-1:0] sr_q, sr_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                hi_q, hi_d;

  logic seg_clk_q, seg_clk_d, seg_pen_q, seg_pen_d, seg_do_q, seg_do_d;
  logic led_clk_q, led_clk_d, led_pen_q, led_pen_d, led_do_q, led_do_d;
  logic seg_ack_q, seg_ack_d, led_ack_q, led_ack_d, busy_q, busy_d;

  logic                grant_v, load_v, gch, active, sclk, sdo;
  logic [SEG_BITS-1:0] seg_src;
  logic [LED_BITS-1:0] led_src;

`ifdef SERIAL_DISP_AUTO_REFRESH_EN
  logic [SEG_BITS-1:0] seg_sh_q, seg_sh_d;
  logic [LED_BITS-1:0] led_sh_q, led_sh_d;
  logic [REF_W-1:0]    ref_q, ref_d;
  logic                refresh_v;
`endif

  // Next-state and next-output logic; outputs are derived from the next state
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    last_d    = last_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    div_d     = div_q;
    hi_d      = hi_q;
    grant_v   = 1'b0;
    load_v    = 1'b0;
    gch       = CH_SEG;
    seg_src   = bus_if.seg_data;
    led_src   = bus_if.led_data;
    seg_ack_d = 1'b0;
    led_ack_d = 1'b0;
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
    seg_sh_d  = seg_sh_q;
    led_sh_d  = led_sh_q;
    ref_d     = '0;
    refresh_v = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus_if.seg_req && bus_if.led_req) begin
          grant_v = 1'b1;
          gch     = ~last_q;
        end else if (bus_if.seg_req) begin
          grant_v = 1'b1;
          gch     = CH_SEG;
        end else if (bus_if.led_req) begin
          grant_v = 1'b1;
          gch     = CH_LED;
        end
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
        else if (ref_q == REF_W'(REFRESH_CYCLES - 1)) begin
          refresh_v = 1'b1;
          gch       = ~last_q;
          seg_src   = seg_sh_q;
          led_src   = led_sh_q;
        end else begin
          ref_d = ref_q + REF_W'(1);
        end
        load_v = grant_v || refresh_v;
        if (grant_v && gch == CH_SEG) seg_sh_d = bus_if.seg_data;
        if (grant_v && gch == CH_LED) led_sh_d = bus_if.led_data;
`else
        load_v = grant_v;
`endif
        if (load_v) begin
          state_d = S_LOAD;
          chan_d  = gch;
          last_d  = gch;
          bit_d   = (gch == CH_SEG) ? BIT_W'(SEG_BITS - 1) : BIT_W'(LED_BITS - 1);
          sr_d    = (gch == CH_SEG) ? seg_src : (SEG_BITS'(led_src) << LED_PAD);
        end
        seg_ack_d = grant_v && (gch == CH_SEG);
        led_ack_d = grant_v && (gch == CH_LED);
      end
      S_LOAD: begin
        state_d = S_SHIFT;
        div_d   = '0;
        hi_d    = 1'b0;
      end
      S_SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!hi_q) begin
            hi_d = 1'b1;
          end else if (bit_q == '0) begin
            hi_d    = 1'b0;
            state_d = S_LATCH;
          end else begin
            hi_d  = 1'b0;
            sr_d  = sr_q << 1;
            bit_d = bit_q - BIT_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_LATCH: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Only the active channel's pins move; the other holds its idle levels
    active    = (state_d == S_LOAD) || (state_d == S_SHIFT);
    sclk      = (state_d == S_SHIFT) && hi_d;
    sdo       = active && sr_d[SEG_BITS-1];
    seg_clk_d = sclk && (chan_d == CH_SEG);
    seg_pen_d = !(active && (chan_d == CH_SEG));
    seg_do_d  = sdo && (chan_d == CH_SEG);
    led_clk_d = sclk && (chan_d == CH_LED);
    led_pen_d = !(active && (chan_d == CH_LED));
    led_do_d  = sdo && (chan_d == CH_LED);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      chan_q    <= CH_SEG;
      last_q    <= CH_LED;
      sr_q      <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      hi_q      <= 1'b0;
      seg_clk_q <= 1'b0;
      seg_pen_q <= 1'b1;
      seg_do_q  <= 1'b0;
      led_clk_q <= 1'b0;
      led_pen_q <= 1'b1;
      led_do_q  <= 1'b0;
      seg_ack_q <= 1'b0;
      led_ack_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
      seg_sh_q  <= '0;
      led_sh_q  <= '0;
      ref_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      last_q    <= last_d;
      sr_q      <= sr_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      hi_q      <= hi_d;
      seg_clk_q <= seg_clk_d;
      seg_pen_q <= seg_pen_d;
      seg_do_q  <= seg_do_d;
      led_clk_q <= led_clk_d;
      led_pen_q <= led_pen_d;
      led_do_q  <= led_do_d;
      seg_ack_q <= seg_ack_d;
      led_ack_q <= led_ack_d;
      busy_q    <= busy_d;
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
      seg_sh_q  <= seg_sh_d;
      led_sh_q  <= led_sh_d;
      ref_q     <= ref_d;
`endif
    end
  end

  assign seg_clk_o      = seg_clk_q;
  assign seg_pen_o      = seg_pen_q;
  assign seg_do_o       = seg_do_q;
  assign led_clk_o      = led_clk_q;
  assign led_pen_o      = led_pen_q;
  assign led_do_o       = led_do_q;
  assign bus_if.seg_ack = seg_ack_q;
  assign bus_if.led_ack = led_ack_q;
  assign bus_if.busy    = busy_q;

endmodule

// File: tb/tb_serial_disp_sched.sv
// Scoreboard bench for serial_disp_sched: frames decoded from the pins are matched
// against expected frames queued when each request is driven.
module tb_serial_disp_sched;
  localparam int unsigned SEG_BITS = 64;
  localparam int unsigned LED_BITS = 16;
  localparam int unsigned CLK_DIV  = 2;
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
  localparam int unsigned REFRESH_CYCLES = 50;
  localparam int IDLE_WAIT = 10;
`else
  localparam int IDLE_WAIT = 100;
`endif

  logic clk = 1'b0;
  logic rst;
  logic seg_clk, seg_pen, seg_do, led_clk, led_pen, led_do;
  always #5 clk = ~clk;

  serial_disp_sched_if #(.SEG_BITS(SEG_BITS), .LED_BITS(LED_BITS)) bus_if ();

  serial_disp_sched #(
    .SEG_BITS(SEG_BITS), .LED_BITS(LED_BITS), .CLK_DIV(CLK_DIV)
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
    , .REFRESH_CYCLES(REFRESH_CYCLES)
`endif
  ) dut (
    .clk(clk), .rst(rst), .bus_if(bus_if),
    .seg_clk_o(seg_clk), .seg_pen_o(seg_pen), .seg_do_o(seg_do),
    .led_clk_o(led_clk), .led_pen_o(led_pen), .led_do_o(led_do)
  );

  typedef struct { logic chan; logic [63:0] bits; int n; int pen_low; logic viol; } frame_t;
  typedef struct { logic chan; logic [63:0] bits; int n; } exp_t;

  frame_t obs_q[$];
  exp_t   exp_q[$];
  int     busy_q[$];
  int     n_checks = 0, n_fail = 0;
  int     exp_seg_acks = 0, exp_led_acks = 0;

  // Pin monitor state, channel 0 = seg, 1 = led
  logic [1:0]  sc, pn, dv, prv_clk, prv_pen, prv_do;
  logic [63:0] acc [2];
  int          cnt [2], plow [2];
  logic        viol [2];
  int          cyc = 0, busy_run = 0, busy_fall_cyc = 0, seg_ack_gap = 0;
  int          seg_ack_pulses = 0, led_ack_pulses = 0, seg_ack_hi = 0, led_ack_hi = 0;
  logic        prv_busy = 1'b0, prv_sack = 1'b0, prv_lack = 1'b0;

  assign sc = {led_clk, seg_clk};
  assign pn = {led_pen, seg_pen};
  assign dv = {led_do, seg_do};

  initial begin
    prv_clk = '0; prv_pen = '1; prv_do = '0;
    for (int c = 0; c < 2; c++) begin acc[c] = '0; cnt[c] = 0; plow[c] = 0; viol[c] = 1'b0; end
  end

  always @(negedge clk) begin
    frame_t f;
    cyc++;
    if (rst) begin
      busy_run = 0;
      for (int c = 0; c < 2; c++) cnt[c] = 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (!pn[c]) begin
          if (prv_pen[c]) begin acc[c] = '0; cnt[c] = 0; plow[c] = 0; viol[c] = 1'b0; end
          plow[c]++;
          if (sc[c] && !prv_clk[c]) begin acc[c] = {acc[c][62:0], dv[c]}; cnt[c]++; end
          if (!pn[1-c] || sc[1-c] || dv[1-c]) viol[c] = 1'b1;
          if (sc[c] && prv_clk[c] && (dv[c] !== prv_do[c])) viol[c] = 1'b1;
        end else if (!prv_pen[c]) begin
          f.chan = 1'(c); f.bits = acc[c]; f.n = cnt[c]; f.pen_low = plow[c]; f.viol = viol[c];
          obs_q.push_back(f);
        end
      end
      if (bus_if.busy) busy_run++;
      else if (prv_busy) begin busy_q.push_back(busy_run); busy_run = 0; busy_fall_cyc = cyc; end
      if (bus_if.seg_ack) begin
        seg_ack_hi++;
        if (!prv_sack) begin seg_ack_pulses++; seg_ack_gap = cyc - busy_fall_cyc; end
      end
      if (bus_if.led_ack) begin
        led_ack_hi++;
        if (!prv_lack) led_ack_pulses++;
      end
    end
    prv_clk = sc; prv_pen = pn; prv_do = dv;
    prv_busy = bus_if.busy; prv_sack = bus_if.seg_ack; prv_lack = bus_if.led_ack;
  end

  // Requester model: holds req until its ack is seen
  always @(negedge clk) begin
    if (bus_if.seg_ack) bus_if.seg_req = 1'b0;
    if (bus_if.led_ack) bus_if.led_req = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic req_seg(input logic [63:0] d, input bit push);
    exp_t e;
    bus_if.seg_data = d;
    bus_if.seg_req  = 1'b1;
    exp_seg_acks++;
    e.chan = 1'b0; e.bits = d; e.n = SEG_BITS;
    if (push) exp_q.push_back(e);
  endtask

  task automatic req_led(input logic [15:0] d);
    exp_t e;
    bus_if.led_data = d;
    bus_if.led_req  = 1'b1;
    exp_led_acks++;
    e.chan = 1'b1; e.bits = 64'(d); e.n = LED_BITS;
    exp_q.push_back(e);
  endtask

  task automatic expect_refresh(input logic chan, input logic [63:0] d, input int n);
    exp_t e;
    e.chan = chan; e.bits = d; e.n = n;
    exp_q.push_back(e);
  endtask

  task automatic next_frame();
    frame_t f;
    exp_t   e;
    int     t = 0, bl;
    while ((obs_q.size() == 0 || busy_q.size() == 0) && t < 4000) begin tick(); t++; end
    check("frame_wait", 64'(t < 4000), 64'd1);
    if (obs_q.size() > 0 && busy_q.size() > 0 && exp_q.size() > 0) begin
      f = obs_q.pop_front(); e = exp_q.pop_front(); bl = busy_q.pop_front();
      check("frame_chan", 64'(f.chan), 64'(e.chan));
      check("frame_bits", f.bits, e.bits);
      check("frame_nbits", 64'(f.n), 64'(e.n));
      check("pen_low_cycles", 64'(f.pen_low), 64'(1 + 2 * CLK_DIV * e.n));
      check("pin_protocol", 64'(f.viol), 64'd0);
      check("busy_cycles", 64'(bl), 64'(1 + 2 * CLK_DIV * e.n + CLK_DIV));
    end
  endtask

  localparam logic [8:0] IDLE_PINS = 9'b010_010_000;

  initial begin
    int t;
    rst = 1'b1;
    bus_if.seg_req = 1'b0; bus_if.led_req = 1'b0;
    bus_if.seg_data = '0;  bus_if.led_data = '0;
    tick(3);
    check("rst_pins", 64'({seg_clk, seg_pen, seg_do, led_clk, led_pen, led_do,
                           bus_if.seg_ack, bus_if.led_ack, bus_if.busy}), 64'(IDLE_PINS));
    rst = 1'b0;
    tick(IDLE_WAIT);
    check("idle_pins", 64'({seg_clk, seg_pen, seg_do, led_clk, led_pen, led_do,
                            bus_if.seg_ack, bus_if.led_ack, bus_if.busy}), 64'(IDLE_PINS));
`ifdef SERIAL_DISP_AUTO_REFRESH_EN
    req_led(16'h00FF);
    next_frame();
    expect_refresh(1'b0, 64'd0, SEG_BITS);
    next_frame();
    expect_refresh(1'b1, 64'h00FF, LED_BITS);
    next_frame();
    tick(10);
    req_led(16'h1234);
    next_frame();
`else
    req_led(16'hA5C3);
    tick();
    check("led_ack_latency", 64'(bus_if.led_ack), 64'd1);
    next_frame();

    // Tie after reset goes to seg, then LED
    req_seg(64'h0123_4567_89AB_CDEF, 1'b1);
    req_led(16'h5A0F);
    next_frame();
    next_frame();

    // Back-to-back LED, seg arrives mid-frame and waits for IDLE
    req_led(16'hFFFF);
    tick(20);
    req_seg(64'hDEAD_BEEF_0000_FFFF, 1'b1);
    next_frame();
    next_frame();
    check("seg_ack_after_latch", 64'(seg_ack_gap), 64'd1);

    // Tie with last grant seg goes to LED
    req_led(16'h8001);
    req_seg(64'h8000_0000_0000_0001, 1'b1);
    next_frame();
    next_frame();

    // Abort a seg frame at bit 7
    req_seg(64'hFFFF_0000_AAAA_5555, 1'b0);
    tick(2);
    t = 0;
    while (cnt[0] < 7 && t < 2000) begin tick(); t++; end
    check("abort_wait", 64'(t < 2000), 64'd1);
    rst = 1'b1;
    tick();
    check("abort_pins", 64'({seg_clk, seg_pen, seg_do, led_clk, led_pen, led_do,
                             bus_if.seg_ack, bus_if.led_ack, bus_if.busy}), 64'(IDLE_PINS));
    rst = 1'b0;
    tick(30);
    check("abort_no_ack", 64'(seg_ack_pulses), 64'(exp_seg_acks));
    check("abort_no_frame", 64'(obs_q.size()), 64'd0);
    req_seg(64'hFFFF_0000_AAAA_5555, 1'b1);
    next_frame();
`endif
    tick(5);
    check("seg_ack_count", 64'(seg_ack_pulses), 64'(exp_seg_acks));
    check("led_ack_count", 64'(led_ack_pulses), 64'(exp_led_acks));
    check("seg_ack_width", 64'(seg_ack_hi), 64'(exp_seg_acks));
    check("led_ack_width", 64'(led_ack_hi), 64'(exp_led_acks));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_disp_sched.md
Name: serial_disp_sched

Overview:
- Scheduler sharing one serial shift engine between the two display chains: seven-segment (seg_clk/seg_pen/seg_do) and LED (led_clk/led_pen/led_do).
- Bus-side requesters post frame updates. The block arbitrates round-robin and captures the winning frame.
- It then shifts the frame MSB-first to that chain's external shift registers and latches it.
- Sits between the I/O bus peripheral logic and the board pins.

Parameters:
- SEG_BITS, 64, seven-segment frame width in bits.
- LED_BITS, 16, LED frame width in bits.
- CLK_DIV, 4, serial clock half-period in clk cycles (>=1).
- REFRESH_CYCLES, 1000000, idle interval between auto-refresh frames (used only with SERIAL_DISP_AUTO_REFRESH_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seg_req  in  1  seg frame request (level, held until seg_ack).
- seg_data  in  SEG_BITS  seg frame; sampled in the grant cycle.
- seg_ack  out  1  one-cycle pulse: seg frame captured.
- led_req  in  1  LED frame request (level, held until led_ack).
- led_data  in  LED_BITS  LED frame; sampled in the grant cycle.
- led_ack  out  1  one-cycle pulse: LED frame captured.
- busy  out  1  high from LOAD through end of LATCH.
- seg_clk / seg_pen / seg_do  out  1 each  seg serial clock / output enable-latch / data.
- led_clk / led_pen / led_do  out  1 each  LED serial clock / output enable-latch / data.

Behaviour:
- Reset values: all *_clk=0, all *_pen=1, all *_do=0, seg_ack=0, led_ack=0, busy=0, state=IDLE, last_grant=LED (so seg wins the first tie).
- FSM IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
- IDLE: requests are sampled only here.
  - Exactly one req high: grant it.
  - Both high: grant the channel not equal to last_grant.
  - Neither high: stay in IDLE.
- LOAD (1 cycle):
  - Capture granted data into the shift register, left-aligned to SEG_BITS.
  - Pulse that channel's ack; update last_grant; busy=1.
  - Drive the granted channel's pen=0.
  - Bit counter = frame width - 1.
- SHIFT: per bit, two phases.
  - Low phase: CLK_DIV cycles, sclk=0, do=current MSB.
  - High phase: CLK_DIV cycles, sclk=1.
  - At the end of the high phase, shift left and decrement the counter.
  - After bit 0's high phase, go to LATCH.
- LATCH: CLK_DIV cycles with sclk=0, do=0, pen=1. Then go to IDLE, busy=0.
- Non-granted channel: holds reset values (clk=0, pen=1, do=0) for the whole frame.
- Frame latency, LOAD to IDLE: 1 + 2*CLK_DIV*N + CLK_DIV cycles (N = LED_BITS or SEG_BITS).
- A req asserted during busy is ignored until IDLE. Requester holds req/data stable until its ack.
- A req dropped before grant produces no transfer and no ack.
- Re-request of the same channel back-to-back: granted again if the other channel is not requesting.
- rst asserted mid-frame: immediate abort. Outputs return to reset values, no ack is generated, and the partial frame is left unlatched (pen forced 1).
- do changes only while sclk=0; there are no glitches on sclk or pen (all outputs registered).

Optional Feature:
- Macro SERIAL_DISP_AUTO_REFRESH_EN.
- Defined:
  - A shadow register per channel keeps the last captured frame; shadows reset to 0.
  - A REFRESH_CYCLES counter runs while in IDLE with no req.
  - On expiry, re-send the shadow of the channel not equal to last_grant, without generating an ack. Counter restarts.
  - Pending requests always take priority over refresh. A req arriving during a refresh frame waits until IDLE.
- Undefined: no shadow registers or counter. Frames are sent only on explicit requests.

Test Plan:
- Reset then idle 100 cycles -> all *_clk=0, *_pen=1, *_do=0, acks=0, busy=0.
- CLK_DIV=2, led_req with led_data=16'hA5C3 -> led_ack pulse 1 cycle after req.
  - led_pen low for 64 SHIFT cycles; led_do MSB-first 1010_0101_1100_0011 sampled on the 16 led_clk rising edges.
  - busy high exactly 67 cycles; seg_* static.
- seg_req and led_req asserted in the same cycle after reset -> seg served first (259 busy cycles), then LED. Repeat both -> LED first this time.
- seg_req asserted mid-LED-frame -> no seg_ack until the LED LATCH ends; seg LOAD in the first IDLE cycle after.
- rst pulsed at bit 7 of a seg frame -> outputs return to reset values within the reset pulse, no seg_ack, and a later request shifts the full 64 bits.
- With SERIAL_DISP_AUTO_REFRESH_EN, REFRESH_CYCLES=50: after an LED frame 16'h00FF, idle -> after 50 idle cycles a seg frame of zeros is sent, then the LED frame 16'h00FF is resent.
  - No acks are generated.
  - A led_req raised in the idle gap is served before the refresh.
